// File: rtl/sgdmac_pkg.sv
// Shared SGDMAC types, command layout and command field helpers.
package sgdmac_pkg;

  localparam int CMD_W       = 48;
  localparam int ADDR_LSB    = 16;
  localparam int LEN_W       = 16;
  localparam int BURST_BYTES = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CPL       = 3'd4
  } sched_state_e;

  function automatic logic [CMD_W-ADDR_LSB-1:0] cmd_dst(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_W-1:ADDR_LSB];
  endfunction

  function automatic logic [LEN_W-1:0] cmd_len(input logic [CMD_W-1:0] cmd);
    return cmd[LEN_W-1:0];
  endfunction

  // Burst-aligned destination keeps every 64 B engine burst inside one 4 KB page.
  function automatic logic cmd_ok(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-ADDR_LSB-1:0] dst;
    logic [LEN_W-1:0]          len;
    dst = cmd_dst(cmd);
    len = cmd_len(cmd);
    return (len != 16'd0) && (len[1:0] == 2'd0) &&
           ((dst & 32'(BURST_BYTES - 1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sgdmac_rr_arb.sv
// Combinational round-robin picker: first requester above 'last', wrapping.
module sgdmac_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o
);

  logic found_s;

  // Scan N slots starting just after the previous winner.
  always_comb begin
    gnt_o     = {N{1'b0}};
    gnt_idx_o = {W{1'b0}};
    found_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found_s && req_i[(int'(last_i) + i) % N]) begin
        found_s                             = 1'b1;
        gnt_o[(int'(last_i) + i) % N]       = 1'b1;
        gnt_idx_o                           = W'((int'(last_i) + i) % N);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sgdmac_wr_sched.sv
// Round-robin scheduler sharing the single SGDMAC write engine among NUM_CH channels.
module sgdmac_wr_sched
  import sgdmac_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req_valid_i,
  input  logic [NUM_CH*CMD_W-1:0] req_cmd_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  input  logic [NUM_CH-1:0]       ch_en_i,
  output logic                    eng_start_o,
  output logic [CMD_W-1:0]        eng_cmd_o,
  input  logic                    eng_done_i,
  output logic                    cpl_valid_o,
  output logic [CH_W-1:0]         cpl_ch_o,
  output logic                    cpl_err_o,
  output logic                    busy_o,
  output logic [15:0]             cpl_cnt_o
);

  sched_state_e       state_q;
  logic [CMD_W-1:0]   cmd_q;
  logic [CH_W-1:0]    cur_ch_q;
  logic [CH_W-1:0]    last_ch_q;
  logic               err_q;
  logic [15:0]        cpl_cnt_q;

  logic [NUM_CH-1:0]  eligible_s;
  logic [NUM_CH-1:0]  gnt_s;
  logic [CH_W-1:0]    gnt_idx_s;
  logic [CMD_W-1:0]   cmd_sel_s;
  logic               cmd_ok_s;

  assign eligible_s = req_valid_i & ch_en_i;
  assign cmd_sel_s  = req_cmd_i[int'(gnt_idx_s)*CMD_W +: CMD_W];
  assign cmd_ok_s   = cmd_ok(cmd_q);

  sgdmac_rr_arb #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .req_i     (eligible_s),
    .last_i    (last_ch_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Ready is masked by reset so a held valid is never acknowledged while in reset.
  assign req_ready_o = (rst_n && (state_q == ST_IDLE)) ? gnt_s : {NUM_CH{1'b0}};
  assign eng_start_o = (state_q == ST_ISSUE) && cmd_ok_s && eng_done_i;
  assign eng_cmd_o   = cmd_q;
  assign cpl_valid_o = (state_q == ST_CPL);
  assign cpl_ch_o    = cur_ch_q;
  assign cpl_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign cpl_cnt_o   = cpl_cnt_q;

  // Command FSM; done is level-sensed, so WAIT_BUSY skips the stale idle cycle after start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= {CMD_W{1'b0}};
      cur_ch_q  <= {CH_W{1'b0}};
      last_ch_q <= CH_W'(NUM_CH - 1);
      err_q     <= 1'b0;
      cpl_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|gnt_s) begin
            cmd_q     <= cmd_sel_s;
            cur_ch_q  <= gnt_idx_s;
            last_ch_q <= gnt_idx_s;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!cmd_ok_s) begin
            err_q   <= 1'b1;
            state_q <= ST_CPL;
          end else if (eng_done_i) begin
            state_q <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!eng_done_i) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (eng_done_i) begin
            state_q <= ST_CPL;
          end
        end
        ST_CPL: begin
          cpl_cnt_q <= cpl_cnt_q + 16'd1;
          err_q     <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sgdmac_wr_sched.sv
// Directed self-checking bench for sgdmac_wr_sched with a level-done engine model.
module tb_sgdmac_wr_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid_i;
  logic [191:0] req_cmd_i;
  logic [3:0]   req_ready_o;
  logic [3:0]   ch_en_i;
  logic         eng_start_o;
  logic [47:0]  eng_cmd_o;
  logic         eng_done_i;
  logic         cpl_valid_o;
  logic [1:0]   cpl_ch_o;
  logic         cpl_err_o;
  logic         busy_o;
  logic [15:0]  cpl_cnt_o;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  sgdmac_wr_sched #(.NUM_CH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_cmd_i   (req_cmd_i),
    .req_ready_o (req_ready_o),
    .ch_en_i     (ch_en_i),
    .eng_start_o (eng_start_o),
    .eng_cmd_o   (eng_cmd_o),
    .eng_done_i  (eng_done_i),
    .cpl_valid_o (cpl_valid_o),
    .cpl_ch_o    (cpl_ch_o),
    .cpl_err_o   (cpl_err_o),
    .busy_o      (busy_o),
    .cpl_cnt_o   (cpl_cnt_o)
  );

  always #5 clk = ~clk;

  // Engine model: done stays high the cycle after start, then low for busy_len cycles.
  logic       model_done_q;
  logic [1:0] eng_ph_q;
  int         eng_cnt_q;
  int         busy_len = 20;
  logic       force_low = 1'b0;
  assign eng_done_i = model_done_q & ~force_low;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_done_q <= 1'b1;
      eng_ph_q     <= 2'd0;
      eng_cnt_q    <= 0;
    end else begin
      case (eng_ph_q)
        2'd0: if (eng_start_o) eng_ph_q <= 2'd1;
        2'd1: begin eng_ph_q <= 2'd2; model_done_q <= 1'b0; eng_cnt_q <= busy_len - 1; end
        2'd2: begin
          if (eng_cnt_q == 0) begin model_done_q <= 1'b1; eng_ph_q <= 2'd0; end
          else eng_cnt_q <= eng_cnt_q - 1;
        end
        default: eng_ph_q <= 2'd0;
      endcase
    end
  end

  int         start_pulses = 0;
  int         cpl_pulses = 0;
  logic [3:0] gnt_log[$];

  always @(negedge clk) begin
    if (eng_start_o === 1'b1) start_pulses++;
    if (cpl_valid_o === 1'b1) cpl_pulses++;
    if (rst_n === 1'b1 && req_ready_o !== 4'b0000) gnt_log.push_back(req_ready_o);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int ch, input logic [47:0] c);
    req_cmd_i[ch*48 +: 48] = c;
  endtask

  task automatic wait_cpl(output bit seen, output logic [1:0] ch, output logic err);
    seen = 1'b0; ch = 2'd0; err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpl_valid_o === 1'b1) begin seen = 1'b1; ch = cpl_ch_o; err = cpl_err_o; break; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (busy_o === 1'b0) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    exp_cnt = 0;
    gnt_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 4'b0000; req_cmd_i = 192'd0; ch_en_i = 4'b1111;
    cyc(); cyc(); cyc();
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready_o); end
    checks++; if (eng_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", eng_start_o); end
    checks++; if (cpl_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cpl_valid: got %b expected 0", cpl_valid_o); end
    checks++; if (cpl_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cpl_cnt_o); end
    checks++; if (eng_cmd_o !== 48'd0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", eng_cmd_o); end
    checks++; if ({cpl_ch_o, cpl_err_o} !== 3'b000) begin errors++; $display("FAIL reset_cpl_fields: got %b expected 000", {cpl_ch_o, cpl_err_o}); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    int s0, c0; bit seen; logic [1:0] ch; logic err;
    s0 = start_pulses; c0 = cpl_pulses; busy_len = 20;
    set_cmd(0, 48'h1000_0000_0100);
    req_valid_i = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready_o); end
    cyc(); req_valid_i = 4'b0000;
    @(negedge clk);
    checks++; if (eng_start_o !== 1'b1) begin errors++; $display("FAIL single_start_t1: got %b expected 1", eng_start_o); end
    checks++; if (eng_cmd_o !== 48'h1000_0000_0100) begin errors++; $display("FAIL single_cmd: got %h expected 100000000100", eng_cmd_o); end
    cyc();
    @(negedge clk);
    checks++; if ({eng_start_o, busy_o} !== 2'b01) begin errors++; $display("FAIL single_t2: got start,busy=%b expected 01", {eng_start_o, busy_o}); end
    wait_cpl(seen, ch, err);
    checks++; if ({seen, ch, err} !== 4'b1000) begin errors++; $display("FAIL single_cpl: got seen,ch,err=%b expected 1000", {seen, ch, err}); end
    exp_cnt++;
    cyc();
    checks++; if (cpl_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL single_cnt: got %0d expected %0d", cpl_cnt_o, exp_cnt); end
    checks++; if (eng_cmd_o !== 48'h1000_0000_0100) begin errors++; $display("FAIL single_cmd_hold: got %h expected 100000000100", eng_cmd_o); end
    checks++; if ((start_pulses - s0) != 1 || (cpl_pulses - c0) != 1) begin errors++; $display("FAIL single_pulses: got start=%0d cpl=%0d expected 1 1", start_pulses - s0, cpl_pulses - c0); end
  endtask

  task automatic test_reject();
    logic [47:0] bad [3];
    int s0;
    bad[0] = 48'h1000_0000_0000;
    bad[1] = 48'h1000_0000_0006;
    bad[2] = 48'h0000_0010_0040;
    s0 = start_pulses;
    for (int k = 0; k < 3; k++) begin
      set_cmd(1, bad[k]);
      req_valid_i = 4'b0010;
      @(negedge clk);
      checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL reject%0d_ready: got %b expected 0010", k, req_ready_o); end
      cyc(); req_valid_i = 4'b0000;
      @(negedge clk);
      checks++; if ({eng_start_o, cpl_valid_o} !== 2'b00) begin errors++; $display("FAIL reject%0d_t1: got start,cpl=%b expected 00", k, {eng_start_o, cpl_valid_o}); end
      cyc();
      @(negedge clk);
      checks++; if ({cpl_valid_o, cpl_err_o, cpl_ch_o} !== 4'b1101) begin errors++; $display("FAIL reject%0d_cpl: got valid,err,ch=%b expected 1101", k, {cpl_valid_o, cpl_err_o, cpl_ch_o}); end
      exp_cnt++;
      cyc();
      checks++; if (cpl_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL reject%0d_cnt: got %0d expected %0d", k, cpl_cnt_o, exp_cnt); end
    end
    checks++; if (start_pulses != s0) begin errors++; $display("FAIL reject_no_start: got %0d starts expected 0", start_pulses - s0); end
  endtask

  task automatic test_done_stall();
    int s0; bit seen; logic [1:0] ch; logic err;
    busy_len = 3; force_low = 1'b1;
    set_cmd(3, 48'h3000_0040_0080);
    req_valid_i = 4'b1000;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL stall_ready: got %b expected 1000", req_ready_o); end
    cyc(); req_valid_i = 4'b0000; s0 = start_pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({eng_start_o, busy_o} !== 2'b01) begin errors++; $display("FAIL stall_hold%0d: got start,busy=%b expected 01", i, {eng_start_o, busy_o}); end
      cyc();
    end
    force_low = 1'b0;
    @(negedge clk);
    checks++; if (eng_start_o !== 1'b1 || eng_cmd_o !== 48'h3000_0040_0080) begin errors++; $display("FAIL stall_release: got start=%b cmd=%h expected 1 300000400080", eng_start_o, eng_cmd_o); end
    wait_cpl(seen, ch, err);
    checks++; if ({seen, ch, err} !== 4'b1110) begin errors++; $display("FAIL stall_cpl: got seen,ch,err=%b expected 1110", {seen, ch, err}); end
    exp_cnt++;
    cyc();
    checks++; if (start_pulses - s0 != 1) begin errors++; $display("FAIL stall_one_start: got %0d expected 1", start_pulses - s0); end
    checks++; if (cpl_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", cpl_cnt_o, exp_cnt); end
  endtask

  task automatic run_grants(input int n, input logic [3:0] en, input string name, input logic [3:0] exp_seq [6]);
    logic [3:0] exp_g;
    do_reset();
    busy_len = 2; ch_en_i = en;
    for (int k = 0; k < 4; k++) set_cmd(k, {32'h2000_0000 + 32'(k * 64), 16'd64});
    req_valid_i = 4'b1111;
    for (int i = 0; i < 2000; i++) begin
      if (gnt_log.size() >= n) break;
      cyc();
    end
    req_valid_i = 4'b0000;
    drain();
    checks++; if (gnt_log.size() < n) begin errors++; $display("FAIL %s_count: got %0d grants expected %0d", name, gnt_log.size(), n); end
    for (int i = 0; i < n && i < gnt_log.size(); i++) begin
      exp_g = exp_seq[i % 6];
      checks++; if (gnt_log[i] !== exp_g) begin errors++; $display("FAIL %s_grant%0d: got %b expected %b", name, i, gnt_log[i], exp_g); end
    end
    checks++; if (cpl_cnt_o !== 16'(gnt_log.size())) begin errors++; $display("FAIL %s_cnt: got %0d expected %0d", name, cpl_cnt_o, gnt_log.size()); end
    ch_en_i = 4'b1111;
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001; seq[5] = 4'b0010;
    run_grants(6, 4'b1111, "rr", seq);
  endtask

  task automatic test_mask();
    logic [3:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b1000;
    seq[3] = 4'b0001; seq[4] = 4'b0010; seq[5] = 4'b1000;
    run_grants(6, 4'b1011, "mask", seq);
  endtask

  task automatic test_reset_mid();
    int c0;
    busy_len = 30;
    set_cmd(0, 48'h2000_0000_0040);
    set_cmd(2, 48'h4000_0000_0040);
    req_valid_i = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL rmid_ready: got %b expected 0100", req_ready_o); end
    cyc(); c0 = cpl_pulses;
    req_valid_i = 4'b0101;
    for (int i = 0; i < 8; i++) cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    checks++; if ({busy_o, req_ready_o, eng_start_o, cpl_valid_o} !== 7'd0) begin errors++; $display("FAIL rmid_ctrl: got busy,ready,start,cpl=%b expected 0000000", {busy_o, req_ready_o, eng_start_o, cpl_valid_o}); end
    checks++; if ({cpl_cnt_o, eng_cmd_o, cpl_ch_o, cpl_err_o} !== 67'd0) begin errors++; $display("FAIL rmid_regs: got cnt=%0d cmd=%h ch=%0d err=%b expected zeros", cpl_cnt_o, eng_cmd_o, cpl_ch_o, cpl_err_o); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant: got %b expected 0001", req_ready_o); end
    cyc(); req_valid_i = 4'b0000;
    drain();
    checks++; if (cpl_pulses - c0 != 1 || cpl_cnt_o !== 16'd1) begin errors++; $display("FAIL rmid_cpl: got pulses=%0d cnt=%0d expected 1 1", cpl_pulses - c0, cpl_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_done_stall();
    test_round_robin();
    test_mask();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
